// File: rtl/instruction_fetch.sv
// Instruction fetch: credit-limited requests to instruction memory, a small
// tagged instruction buffer toward the decoder, and redirect/drain handling.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int          PW     = $clog2(DEPTH);
    localparam int          CW     = $clog2(DEPTH + 1);
    localparam logic [CW:0] LDEPTH = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } state_t;

    state_t          r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_issued;
    logic            r_inflight;
    logic [31:0]     r_data [DEPTH];
    logic [31:0]     r_tag  [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_redir;
    logic [CW:0]     w_used;
    logic            w_grant;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [31:0]     w_redir_pc;

    assign w_redir    = (r_state != BOOT) & redirect_valid;
    assign w_redir_pc = redirect_pc & ~32'h3;

    // Credit counts the response still on the bus, so the buffer never overflows
    // and the request never depends on this cycle's pop.
    assign w_used   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign imem_req = (r_state == FETCH) & ~halt & ~redirect_valid
                    & (w_used < LDEPTH);
    assign imem_addr = r_pc;
    assign w_grant   = imem_req & imem_gnt;

    assign w_empty     = (r_count == '0);
    assign instr_valid = ~w_empty;
    assign w_pop       = instr_valid & instr_ready & ~w_redir;
    assign w_push      = r_inflight & ~w_redir;
    assign instruction = w_empty ? NOP : r_data[r_rd_ptr];
    assign instr_pc    = w_empty ? RESET_PC : r_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_issued   <= RESET_PC;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_grant;
            if (w_grant) begin
                r_pc     <= r_pc + 32'd4;
                r_issued <= r_pc;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push & ~w_pop)
                r_count <= r_count + 1'b1;
            else if (~w_push & w_pop)
                r_count <= r_count - 1'b1;

            unique case (r_state)
                BOOT:         r_state <= FETCH;
                FETCH, DRAIN: r_state <= (w_redir & r_inflight) ? DRAIN : FETCH;
                default:      r_state <= BOOT;
            endcase

            // Redirect wins over everything: the word on the bus is dropped.
            if (w_redir) begin
                r_pc     <= w_redir_pc;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_data[r_wr_ptr] <= imem_rdata;
            r_tag[r_wr_ptr]  <= r_issued;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && ({1'b0, r_count} == LDEPTH)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed per-cycle vector bench for instruction_fetch (DEPTH=4 instance)
// plus a wrap-around sequence on a DEPTH=2 instance at the top of memory.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n, gnt, rdy, halt, rv;
    logic [31:0] rpc;
    logic        req, ivalid;
    logic [31:0] addr, rdata, instr, ipc;

    logic        w_rst_n, w_gnt, w_rdy, w_halt, w_rv;
    logic [31:0] w_rpc;
    logic        w_req, w_ivalid;
    logic [31:0] w_addr, w_rdata, w_instr, w_ipc;

    int checks = 0;
    int errors = 0;

    logic [31:0] gq[$];
    logic [31:0] pq[$];
    logic [31:0] iq[$];

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rdy;
        logic        halt;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        nop;
    } vec_t;

    vec_t tv[$];

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req), .imem_addr(addr), .imem_gnt(gnt), .imem_rdata(rdata),
        .redirect_valid(rv), .redirect_pc(rpc), .halt(halt),
        .instr_valid(ivalid), .instr_ready(rdy),
        .instruction(instr), .instr_pc(ipc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_w (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rdata(w_rdata),
        .redirect_valid(w_rv), .redirect_pc(w_rpc), .halt(w_halt),
        .instr_valid(w_ivalid), .instr_ready(w_rdy),
        .instruction(w_instr), .instr_pc(w_ipc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem = 32'h0020_81B3;
            32'h0000_0004: mem = 32'h0040_A183;
            default:       mem = a ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Memory model: data one cycle after the grant, garbage otherwise.
    always @(posedge clk) begin
        rdata   <= (req && gnt) ? mem(addr) : 32'hBAD0_BAD0;
        w_rdata <= (w_req && w_gnt) ? mem(w_addr) : 32'hBAD0_BAD0;
        if (w_rst_n && w_req && w_gnt) gq.push_back(w_addr);
        if (w_rst_n && w_ivalid && w_rdy) begin
            pq.push_back(w_ipc);
            iq.push_back(w_instr);
        end
    end

    function automatic vec_t mk(
        input logic r, input logic g, input logic y, input logic h,
        input logic v, input logic [31:0] p,
        input logic eq, input logic [31:0] ea, input logic ev,
        input logic [31:0] ep, input logic en
    );
        vec_t t;
        t.rst = r; t.gnt = g; t.rdy = y; t.halt = h; t.rv = v; t.rpc = p;
        t.req = eq; t.addr = ea; t.valid = ev; t.pc = ep; t.nop = en;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        w_rst_n = 1'b0; w_gnt = 1'b1; w_rdy = 1'b1;
        w_halt = 1'b0; w_rv = 1'b0; w_rpc = 32'h0;
        repeat (2) @(negedge clk);
        w_rst_n = 1'b1;
    end

    initial begin
        rst_n = 1'b0; gnt = 1'b1; rdy = 1'b0;
        halt = 1'b0; rv = 1'b0; rpc = 32'h0;

        //          rst gnt rdy hlt rv  rpc       req addr      vld pc        nop
        tv.push_back(mk(0, 1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1));
        tv.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1));
        tv.push_back(mk(1, 1, 0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   0));
        tv.push_back(mk(1, 1, 0, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   0));
        tv.push_back(mk(1, 1, 0, 0, 0, 32'h0,   1, 32'h8,   1, 32'h0,   0));
        tv.push_back(mk(1, 1, 0, 0, 0, 32'h0,   1, 32'hC,   1, 32'h0,   0));
        tv.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0,   0));
        tv.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h14,  1, 32'h8,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h18,  1, 32'hC,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h1C,  1, 32'h10,  0));
        tv.push_back(mk(1, 1, 1, 0, 1, 32'h103, 0, 32'h20,  1, 32'h14,  0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0,   0));
        tv.push_back(mk(1, 1, 0, 1, 0, 32'h0,   0, 32'h108, 1, 32'h100, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 32'h0,   0, 32'h108, 1, 32'h100, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 32'h0,   0, 32'h108, 1, 32'h100, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 32'h0,   0, 32'h108, 1, 32'h104, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 32'h0,   0, 32'h108, 0, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h108, 0, 32'h0,   0));
        tv.push_back(mk(0, 1, 1, 0, 0, 32'h0,   1, 32'h10C, 0, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   1));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 1, 32'h207, 0, 32'hC,   1, 32'h4,   0));
        tv.push_back(mk(1, 1, 1, 0, 1, 32'h301, 0, 32'h204, 0, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h300, 0, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h304, 0, 32'h0,   0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h308, 1, 32'h300, 0));
        tv.push_back(mk(1, 0, 1, 0, 0, 32'h0,   1, 32'h30C, 1, 32'h304, 0));
        tv.push_back(mk(1, 0, 1, 0, 0, 32'h0,   1, 32'h30C, 1, 32'h308, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 32'h0,   1, 32'h30C, 0, 32'h0,   0));

        repeat (2) @(posedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst_n = tv[i].rst; gnt = tv[i].gnt; rdy = tv[i].rdy;
            halt = tv[i].halt; rv = tv[i].rv; rpc = tv[i].rpc;
            #1;
            chk($sformatf("row%0d imem_req", i), {31'd0, req}, {31'd0, tv[i].req});
            chk($sformatf("row%0d imem_addr", i), addr, tv[i].addr);
            chk($sformatf("row%0d instr_valid", i), {31'd0, ivalid},
                {31'd0, tv[i].valid});
            if (tv[i].valid) begin
                chk($sformatf("row%0d instr_pc", i), ipc, tv[i].pc);
                chk($sformatf("row%0d instruction", i), instr, mem(tv[i].pc));
            end
            if (tv[i].nop) begin
                chk($sformatf("row%0d nop_instr", i), instr, 32'h0000_0013);
                chk($sformatf("row%0d nop_pc", i), ipc, 32'h0000_0000);
            end
        end

        for (int k = 0; k < 40 && (gq.size() < 3 || pq.size() < 3); k++)
            @(posedge clk);
        #1;
        checks++;
        if (gq.size() < 3 || pq.size() < 3) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d grants %0d pops required 3 each",
                     gq.size(), pq.size());
        end else begin
            chk("wrap_grant0", gq[0], 32'hFFFF_FFF8);
            chk("wrap_grant1", gq[1], 32'hFFFF_FFFC);
            chk("wrap_grant2", gq[2], 32'h0000_0000);
            chk("wrap_pop_pc0", pq[0], 32'hFFFF_FFF8);
            chk("wrap_pop_pc1", pq[1], 32'hFFFF_FFFC);
            chk("wrap_pop_pc2", pq[2], 32'h0000_0000);
            chk("wrap_pop_instr0", iq[0], mem(32'hFFFF_FFF8));
            chk("wrap_pop_instr2", iq[2], 32'h0020_81B3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the address of the first fetch after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the instruction-buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; valid while imem_req=1.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rdata  input  32  fetched word; valid exactly one cycle after the granting cycle.
REQ-009 redirect_valid  input  1  branch or jump redirect from downstream.
REQ-010 redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 00.
REQ-011 halt  input  1  suppresses new requests; does not flush.
REQ-012 instr_valid  output  1  instruction word presented to instruction_decoder.
REQ-013 instr_ready  input  1  decoder consumes the word this cycle.
REQ-014 instruction  output  32  word to decoder (drives decoder's instruction port).
REQ-015 instr_pc  output  32  address of the presented instruction.

Function
REQ-016 SHALL implement an FSM with three states:
- BOOT: entered on reset; no request.
- FETCH: normal operation.
- DRAIN: a response is in flight when redirect occurs.
REQ-017 BOOT SHALL go to FETCH unconditionally one cycle after rst_n is high.
REQ-018 The PC register SHALL hold the next fetch address; imem_addr=PC.
REQ-019 In FETCH, imem_req SHALL be 1 iff halt=0, redirect_valid=0, and occupancy+inflight<DEPTH.
- occupancy = buffered entries; inflight = 1 if the previous cycle was a grant, else 0.
REQ-020 On a grant (imem_req & imem_gnt), PC SHALL advance by 4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); the issued address is stored for tagging.
REQ-021 The cycle after a grant, {imem_rdata, issued address} SHALL be written to the FIFO unless that response is marked discard.
REQ-022 The FIFO head SHALL drive instruction/instr_pc; instr_valid = (occupancy>0).
REQ-023 Pop occurs when instr_valid & instr_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-024 Order SHALL be preserved: words are presented in grant order, with no duplication and no loss.
REQ-025 The credit rule (REQ-019) guarantees no push into a full FIFO; a push at full is a design error (assertion).
REQ-026 On redirect_valid=1 in any non-BOOT state:
- the FIFO is flushed and instr_valid=0 next cycle;
- PC<=redirect_pc & ~3;
- no request is issued that cycle.
REQ-027 If a grant occurred in the cycle of the redirect, or the cycle before it, that response SHALL be marked discard.
- The FSM enters DRAIN for one cycle and FETCH resumes the following cycle.
REQ-028 A redirect arriving while in DRAIN SHALL overwrite PC again and extend DRAIN by the same rule.
REQ-029 A redirect takes priority over pop, push, and grant in the same cycle.
REQ-030 halt=1 SHALL block new requests only; in-flight responses still push, and buffered words still drain.
REQ-031 All outputs SHALL be registered or derived from the FIFO head/PC only; there is no combinational path from instr_ready to imem_req.

Reset
REQ-032 While rst_n=0 at a clock edge:
- PC<=RESET_PC, FIFO empty, inflight=0, discard=0, state<=BOOT;
- imem_req=0, instr_valid=0, instruction=32'h0000_0013 (NOP), instr_pc=RESET_PC.
REQ-033 Reset asserted mid-operation SHALL abandon any in-flight response; a rdata arriving the cycle after reset SHALL NOT be buffered.

Verification
REQ-034 Streaming: reset release, imem_gnt=1, instr_ready=1.
- Expect imem_addr 0,4,8,... one per cycle after BOOT.
- Expect instr_valid from cycle 3 with instr_pc 0,4,8 and instruction = rdata returned.
REQ-035 Backpressure: instr_ready=0 with gnt=1.
- Expect exactly DEPTH grants, then imem_req=0.
- Raising instr_ready pops words in order (e.g. the ADD word 0x002081B3 first, then the LW word 0x0040A183).
REQ-036 Redirect during in-flight: grant at address 0x8, then redirect_valid with redirect_pc=0x103 in the next cycle.
- Expect that response dropped and PC=0x100.
- Expect the next imem_addr=0x100 after DRAIN, and the first instr_pc out = 0x100.
REQ-037 Wrap: RESET_PC=32'hFFFF_FFF8, continuous grants.
- Expect addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 Halt and mid-run reset:
- halt=1 stops imem_req; queued words still pop.
- Asserting rst_n=0 with a pending grant yields instr_valid=0 and instruction=0x00000013 after the edge, and no stale push.
